if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage pipeline, directly upstream of the decode stage. Owns the PC register and the instruction-memory request/response handshake, and drives the IF/ID pipeline register that supplies `inst_i`/`pc_plus4` to decode. Accepts stall from the hazard unit and branch/jump redirects resolved in decode, squashing wrong-path fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INST`, default 32'h0000_0000: instruction word driven into IF/ID on a bubble (MIPS `sll $0,$0,0`).

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall_i`  in  1  hazard unit: hold PC and IF/ID.
- `redirect_i`  in  1  decode's Branch_or_Jump: taken branch/jump.
- `redirect_addr_i`  in  32  decode's Branch_or_Jump_addr; bits [1:0] ignored and forced to 0.
- `imem_req_o`  out  1  fetch request valid.
- `imem_addr_o`  out  32  fetch address, word aligned.
- `imem_ready_i`  in  1  memory accepts request when `imem_req_o & imem_ready_i`.
- `imem_rvalid_i`  in  1  response valid; exactly one per accepted request, in order, at least one cycle after acceptance.
- `imem_rdata_i`  in  32  instruction word.
- `inst_o`  out  32  IF/ID instruction, to decode `inst_i`.
- `pc_plus4_o`  out  32  IF/ID address of `inst_o` plus 4, mod 2^32.
- `inst_valid_o`  out  1  IF/ID holds a real instruction (0 = bubble).
- `fetch_busy_o`  out  1  request outstanding or waiting on memory.

## Operation
- `redirect_i` is honoured only when `stall_i`=0 (decode operands are invalid while stalled); `take_redir = redirect_i & ~stall_i`.
- At most one request outstanding. States:
  - REQ: `imem_req_o`=1, address `pc_q`. On handshake -> WAIT. `take_redir` without handshake: `pc_q`<=target, stay REQ. `take_redir` with handshake: `pc_q`<=target, -> DROP.
  - WAIT: await `imem_rvalid_i`. On rvalid with `take_redir`: discard data, `pc_q`<=target, -> REQ. On rvalid with `stall_i`: latch data into hold buffer, -> HOLD. On rvalid, neither: deliver to IF/ID, `pc_q`<=`pc_q`+4, same cycle drive `imem_req_o`=1 with address `pc_q`+4; handshake -> WAIT, else -> REQ. `take_redir` without rvalid: `pc_q`<=target, -> DROP.
  - HOLD: no request. When `stall_i`=0: `take_redir` -> discard buffer, `pc_q`<=target, -> REQ; else deliver buffer, `pc_q`<=`pc_q`+4, -> REQ.
  - DROP: await `imem_rvalid_i`, discard data, -> REQ (target already in `pc_q`).
- IF/ID register: when `stall_i`=1 holds all fields. When `stall_i`=0 loads the delivered instruction (`inst_o`=data, `pc_plus4_o`=fetch PC+4, `inst_valid_o`=1), else a bubble (`inst_o`=NOP_INST, `inst_valid_o`=0, `pc_plus4_o` held). `take_redir` always forces a bubble.
- `fetch_busy_o` = state in {REQ, WAIT, DROP}.
- PC arithmetic 32-bit, wraps 32'hFFFF_FFFC -> 0.

## Timing
- Reset values: state REQ, `pc_q`=RESET_PC, `inst_o`=NOP_INST, `pc_plus4_o`=0, `inst_valid_o`=0, hold buffer invalid. `imem_req_o`=1 in the first cycle after reset release.
- Zero-wait memory (ready=1, rvalid next cycle): first instruction in IF/ID 2 edges after reset release, then one per cycle.
- Redirect seen in cycle N: target request issued no later than cycle N+1 (DROP adds the outstanding response latency).
- Reset asserted mid-request: state cleared immediately; a late rvalid arriving in REQ is ignored.

## Structure
- Shared pipeline package: `NOP_INST`, `RESET_PC` default, fetch state enum (REQ, WAIT, HOLD, DROP).
- One sub-module: `if_id_reg` (IF/ID register with hold/bubble controls); FSM and PC stay in `if_stage`.

## Test plan
- Zero-wait sequential fetch from RESET_PC=0, mem[i]=i+0x100 -> `inst_o` 0x100,0x101,… on consecutive cycles, `pc_plus4_o` 4,8,12,…
- `stall_i` high 3 cycles while rvalid arrives -> HOLD; IF/ID frozen; after release, buffered word delivered once, none lost or duplicated.
- `redirect_i`=1, addr 0x0000_0040 while WAIT with no rvalid -> DROP, stale response discarded, next delivered `pc_plus4_o`=0x44, one bubble with `inst_valid_o`=0.
- `redirect_i`=1 together with `stall_i`=1 -> ignored; PC and IF/ID unchanged.
- `imem_ready_i` low 4 cycles -> `imem_req_o`/`imem_addr_o` held stable, `fetch_busy_o`=1, bubbles into decode.
- PC at 0xFFFF_FFFC fetched -> `pc_plus4_o`=0, next request address 0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch stage: reset/bubble words, the fetch
// sequencer state encoding and a small address helper.
package if_stage_pkg;

  // Instruction word used for bubbles (MIPS sll $0,$0,0).
  localparam logic [31:0] IF_NOP_INST = 32'h0000_0000;

  // Default first fetch address after reset.
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

  // Fetch sequencer states.
  //   ST_REQ  : request presented at pc_q
  //   ST_WAIT : request accepted, response pending, result wanted
  //   ST_HOLD : response captured while decode was stalled
  //   ST_DROP : response pending for a wrong-path request, to be discarded
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_stage_id_reg.sv
// IF/ID pipeline register. Freezes on hold, inserts a bubble when asked
// or when no instruction is delivered, otherwise captures the delivered
// instruction and its return address.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = IF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        bubble,
  input  logic        load,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] inst,
  output logic [31:0] pc_plus4,
  output logic        inst_valid
);

  // Pipeline register: hold has priority, then a forced bubble, then load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst       <= NOP_INST;
      pc_plus4   <= 32'h0000_0000;
      inst_valid <= 1'b0;
    end else if (!hold) begin
      if (bubble || !load) begin
        // pc_plus4 is left alone on a bubble; only the word and valid change.
        inst       <= NOP_INST;
        inst_valid <= 1'b0;
      end else begin
        inst       <= inst_in;
        pc_plus4   <= pc_plus4_in;
        inst_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage. Owns the PC and the single-outstanding
// instruction-memory handshake, honours hazard stalls and decode-resolved
// redirects, and feeds decode through the IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC,
  parameter logic [31:0] NOP_INST = IF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_plus4_o,
  output logic        inst_valid_o,
  output logic        fetch_busy_o
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  pc_next;
  logic [31:0]  target;
  logic [31:0]  hold_data_q;
  logic [31:0]  deliver_data;
  logic         take_redir;
  logic         deliver;
  logic         hold_load;

  // Decode operands are meaningless while stalled, so a redirect only counts
  // when the pipeline is moving.
  assign take_redir = redirect_i & ~stall_i;
  assign target     = word_align(redirect_addr_i);
  // 32-bit add wraps 32'hFFFF_FFFC to 0 naturally.
  assign pc_next    = pc_q + 32'd4;

  assign fetch_busy_o = (state_q != ST_HOLD);

  // Next-state, next-PC and memory request decode for the fetch sequencer.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    imem_req_o   = 1'b0;
    imem_addr_o  = pc_q;
    deliver      = 1'b0;
    deliver_data = imem_rdata_i;
    hold_load    = 1'b0;

    unique case (state_q)
      ST_REQ: begin
        // A response seen here belongs to a request killed by reset; ignore it.
        imem_req_o = 1'b1;
        if (take_redir) begin
          pc_d    = target;
          // If the old address was accepted this cycle its response must be
          // swallowed before the target is requested.
          state_d = imem_ready_i ? ST_DROP : ST_REQ;
        end else if (imem_ready_i) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (imem_rvalid_i) begin
          if (take_redir) begin
            pc_d    = target;
            state_d = ST_REQ;
          end else if (stall_i) begin
            hold_load = 1'b1;
            state_d   = ST_HOLD;
          end else begin
            // Deliver and issue the next sequential fetch in the same cycle
            // to sustain one instruction per cycle on a zero-wait memory.
            deliver     = 1'b1;
            pc_d        = pc_next;
            imem_req_o  = 1'b1;
            imem_addr_o = pc_next;
            state_d     = imem_ready_i ? ST_WAIT : ST_REQ;
          end
        end else if (take_redir) begin
          pc_d    = target;
          state_d = ST_DROP;
        end
      end

      ST_HOLD: begin
        if (!stall_i) begin
          if (take_redir) begin
            pc_d = target;
          end else begin
            deliver      = 1'b1;
            deliver_data = hold_data_q;
            pc_d         = pc_next;
          end
          state_d = ST_REQ;
        end
      end

      ST_DROP: begin
        // A further redirect while draining just retargets the PC.
        if (take_redir) begin
          pc_d = target;
        end
        if (imem_rvalid_i) begin
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // Sequencer state and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_REQ;
      pc_q    <= word_align(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Capture a response that arrives while decode is stalled; validity is
  // carried by the ST_HOLD state, so the data itself needs no reset.
  always_ff @(posedge clk) begin
    if (hold_load) begin
      hold_data_q <= imem_rdata_i;
    end
  end

  if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold        (stall_i),
    .bubble      (take_redir),
    .load        (deliver),
    .inst_in     (deliver_data),
    .pc_plus4_in (pc_next),
    .inst        (inst_o),
    .pc_plus4    (pc_plus4_o),
    .inst_valid  (inst_valid_o)
  );

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: a memory responder with random latency and a
// transaction-level model of the expected instruction stream.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] pc_plus4_o;
  logic        inst_valid_o;
  logic        fetch_busy_o;

  always #5 clk = ~clk;

  if_stage #(
    .RESET_PC(RST_PC),
    .NOP_INST(NOP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ready_i    (imem_ready_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .inst_o          (inst_o),
    .pc_plus4_o      (pc_plus4_o),
    .inst_valid_o    (inst_valid_o),
    .fetch_busy_o    (fetch_busy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Program memory contents: word i holds i + 0x100.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) + 32'h100;
  endfunction

  // Outstanding memory transactions: address, whether the fetched word is
  // still on the program path, and remaining response delay.
  typedef struct {
    logic [31:0] addr;
    bit          live;
    int          dly;
  } rsp_t;
  rsp_t pend[$];

  // Program-order model
  logic [31:0] exp_pc;          // address of next instruction decode must see
  bit          held_v;          // fetched word waiting out a stall
  logic [31:0] held_d;
  logic [31:0] m_inst, m_pc4;   // expected IF/ID contents
  bit          m_valid;
  bit          prev_req_pend;   // last cycle's request was left unaccepted
  logic [31:0] prev_addr;
  bit          chk_first;
  int          n_deliv = 0;

  int p_stall, p_redir, p_ready, dly_min, dly_max;

  task automatic set_knobs(input int ps, input int pr, input int py, input int dmin, input int dmax);
    p_stall = ps; p_redir = pr; p_ready = py; dly_min = dmin; dly_max = dmax;
  endtask

  task automatic model_reset();
    exp_pc        = RST_PC;
    held_v        = 0;
    m_inst        = NOP;
    m_pc4         = 32'h0;
    m_valid       = 0;
    prev_req_pend = 0;
  endtask

  // One clock cycle. Entered and left at posedge+1.
  task automatic step(input bit rnd);
    bit          take, deliver, hs;
    logic [31:0] dd, tgt;
    rsp_t        r;
    int          outstanding;
    if (rnd) begin
      stall_i      = ($urandom_range(99) < p_stall);
      redirect_i   = ($urandom_range(99) < p_redir);
      if ($urandom_range(9) == 0) redirect_addr_i = 32'hFFFF_FFF0 | $urandom_range(15);
      else                        redirect_addr_i = $urandom_range(255);
      imem_ready_i = ($urandom_range(99) < p_ready);
    end
    if (pend.size() > 0 && pend[0].dly == 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end

    @(negedge clk);
    outstanding = pend.size();
    check_eq("fetch_busy", fetch_busy_o, (imem_req_o || outstanding > 0));
    if (chk_first) begin
      check_eq("first_req", imem_req_o, 1);
      check_eq("first_addr", imem_addr_o, RST_PC);
      chk_first = 0;
    end
    if (prev_req_pend) begin
      check_eq("req_held", imem_req_o, 1);
      check_eq("addr_held", imem_addr_o, prev_addr);
    end
    if (imem_req_o && outstanding == 0)
      check_eq("req_addr", imem_addr_o, exp_pc);
    if (imem_req_o && imem_rvalid_i && pend[0].live)
      check_eq("req_addr_next", imem_addr_o, exp_pc + 32'd4);

    // What happens at the coming edge
    take    = redirect_i && !stall_i;
    tgt     = {redirect_addr_i[31:2], 2'b00};
    hs      = imem_req_o && imem_ready_i;
    deliver = 0;
    dd      = 32'h0;
    if (held_v && !stall_i) begin
      held_v = 0;
      if (!take) begin deliver = 1; dd = held_d; end
    end
    if (imem_rvalid_i) begin
      r = pend.pop_front();
      if (r.live && !take) begin
        if (stall_i) begin held_v = 1; held_d = imem_rdata_i; end
        else begin deliver = 1; dd = imem_rdata_i; end
      end
    end else if (pend.size() > 0) begin
      pend[0].dly--;
    end
    if (!stall_i) begin
      if (deliver) begin
        m_valid = 1; m_inst = dd; m_pc4 = exp_pc + 32'd4;
        exp_pc  = exp_pc + 32'd4;
        n_deliv++;
      end else begin
        m_valid = 0; m_inst = NOP;
      end
    end
    if (take) begin
      exp_pc = tgt;
      foreach (pend[i]) pend[i].live = 0;
    end
    if (hs) begin
      check_eq("one_outstanding", pend.size(), 0);
      r.addr = imem_addr_o;
      r.live = !take && (imem_addr_o == exp_pc);
      r.dly  = $urandom_range(dly_max, dly_min);
      pend.push_back(r);
    end
    prev_req_pend = imem_req_o && !hs && !take;
    prev_addr     = imem_addr_o;

    @(posedge clk);
    #1;
    check_eq("ifid_valid", inst_valid_o, m_valid);
    check_eq("ifid_inst", inst_o, m_inst);
    check_eq("ifid_pc4", pc_plus4_o, m_pc4);
  endtask

  // Step with the current inputs until the next instruction reaches decode,
  // then compare it against the expected address and word.
  task automatic run_until_deliver(input string tag, input int budget,
                                   input logic [31:0] exp_pc4, input logic [31:0] exp_inst);
    int start;
    int k;
    start = n_deliv;
    k     = 0;
    while (n_deliv == start && k < budget) begin
      step(0);
      k++;
    end
    check_eq({tag, "_arrived"}, (n_deliv != start), 1);
    check_eq({tag, "_pc4"}, pc_plus4_o, exp_pc4);
    check_eq({tag, "_inst"}, inst_o, exp_inst);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    foreach (pend[i]) begin pend[i].live = 0; pend[i].dly = 0; end
    model_reset();
    #1;
    check_eq("rst_inst", inst_o, NOP);
    check_eq("rst_pc4", pc_plus4_o, 32'h0);
    check_eq("rst_valid", inst_valid_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    chk_first = 1;
  endtask

  initial begin
    int k;
    rst_n           = 1'b0;
    stall_i         = 1'b0;
    redirect_i      = 1'b0;
    redirect_addr_i = 32'h0;
    imem_ready_i    = 1'b1;
    imem_rvalid_i   = 1'b0;
    imem_rdata_i    = 32'h0;
    chk_first       = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Zero-wait sequential fetch
    set_knobs(0, 0, 100, 0, 0);
    step(1);
    step(1);
    check_eq("seq0_inst", inst_o, 32'h100);
    check_eq("seq0_pc4", pc_plus4_o, 32'h4);
    check_eq("seq0_valid", inst_valid_o, 1);
    step(1);
    check_eq("seq1_inst", inst_o, 32'h101);
    check_eq("seq1_pc4", pc_plus4_o, 32'h8);
    step(1);
    check_eq("seq2_pc4", pc_plus4_o, 32'hC);
    repeat (8) step(1);

    // Stall for 3 cycles while a response arrives
    set_knobs(0, 0, 100, 1, 1);
    k = 0;
    while (!(pend.size() > 0 && pend[0].dly == 1) && k < 10) begin step(0); k++; end
    stall_i = 1'b1;
    repeat (3) step(0);
    stall_i = 1'b0;
    repeat (6) step(0);

    // Redirect while waiting with no response
    set_knobs(0, 0, 100, 3, 3);
    k = 0;
    while (!(pend.size() > 0 && pend[0].dly == 3) && k < 10) begin step(0); k++; end
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h0000_0043;
    step(0);
    check_eq("redir_bubble", inst_valid_o, 0);
    redirect_i = 1'b0;
    run_until_deliver("redir", 20, 32'h44, 32'h110);

    // Redirect during a stall is ignored
    stall_i         = 1'b1;
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h0000_0080;
    repeat (2) step(0);
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    repeat (8) step(0);

    // Memory not ready for 4 cycles
    set_knobs(0, 0, 100, 0, 0);
    repeat (4) step(0);
    imem_ready_i = 1'b0;
    repeat (4) step(0);
    check_eq("busy_not_ready", fetch_busy_o, 1);
    imem_ready_i = 1'b1;
    repeat (4) step(0);

    // PC wraps from the top of the address space
    redirect_i      = 1'b1;
    redirect_addr_i = 32'hFFFF_FFFE;
    step(0);
    redirect_i = 1'b0;
    run_until_deliver("wrap", 20, 32'h0, 32'h4000_00FF);
    run_until_deliver("wrap_next", 5, 32'h4, 32'h100);

    // Randomized traffic
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0:       set_knobs(20, 5, 70, 0, 2);
        1:       set_knobs(40, 15, 50, 0, 4);
        2:       set_knobs(10, 30, 90, 0, 1);
        default: set_knobs(30, 10, 30, 1, 3);
      endcase
      repeat (700) step(1);
    end

    // Reset while a request is outstanding; a late response follows release
    stall_i      = 1'b0;
    redirect_i   = 1'b0;
    imem_ready_i = 1'b1;
    set_knobs(0, 0, 100, 3, 3);
    k = 0;
    while (!(pend.size() > 0 && pend[0].dly >= 2) && k < 20) begin step(0); k++; end
    do_reset();
    set_knobs(0, 0, 100, 0, 0);
    run_until_deliver("post_rst", 10, 32'h4, 32'h100);
    repeat (5) step(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
